// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped LSB-first over WIDTH cycles.
// Latency WIDTH clocks from accepting edge to done; one op per WIDTH+2 clocks.
// Backpressure: start is only sampled in IDLE; ignored while busy is high.

module full_adder (
    input  logic ai,
    input  logic bi,
    input  logic cini,
    output logic si,
    output logic couti
);
    assign si    = ai ^ bi ^ cini;
    assign couti = (ai & bi) | (cini & (ai ^ bi));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             si;
    logic             couti;
    logic [WIDTH-1:0] sr_next;
    logic             last_bit;

    full_adder u_fa (
        .ai    (sa[0]),
        .bi    (sb[0]),
        .cini  (carry),
        .si    (si),
        .couti (couti)
    );

    assign sr_next  = {si, sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        // Subtraction is a + ~b + 1: invert b and seed the carry with op.
                        sb    <= op ? ~b : b;
                        carry <= op;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= sr_next;
                    carry <= couti;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        result <= sr_next;
                        cout   <= couti;
                        ovf    <= carry ^ couti;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_addsub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        checks++;
        if ({busy, done, result, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy, done, result, cout, ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one operation and check latency, result flags, hold and return to idle.
    task automatic run_op(input string name, input logic o, input logic [7:0] ia,
                          input logic [7:0] ib, input logic [7:0] er,
                          input logic ec, input logic eo);
        int n;
        logic [7:0] held;
        held = result;
        op = o; a = ia; b = ib; start = 1'b1;
        tick();              // T0 accepting edge
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_after_accept: got %b want 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (done !== 1'b1 && result !== held) begin
                errors++;
                $display("FAIL %s_partial_visible: got result=%h want held %h", name, result, held);
            end
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL %s_latency: got %0d clocks want 8", name, n);
        end
        checks++;
        if ({result, cout, ovf} !== {er, ec, eo}) begin
            errors++;
            $display("FAIL %s_value: got result=%h cout=%b ovf=%b want result=%h cout=%b ovf=%b",
                     name, result, cout, ovf, er, ec, eo);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b want 1", name, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== er) begin
            errors++;
            $display("FAIL %s_idle_after_done: got done=%b busy=%b result=%h want 0 0 %h",
                     name, done, busy, result, er);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_low_2clk: got %b want 0", name, busy);
        end
    endtask

    task automatic test_add();
        run_op("add_25_1a", 1'b0, 8'h25, 8'h1A, 8'h3F, 1'b0, 1'b0);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        run_op("sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_stability();
        int n;
        int pulses;
        op = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
        tick();
        n = 0;
        pulses = 0;
        while (done !== 1'b1 && n < 20) begin
            start = ~start; a = ~a; b = b + 8'h37; op = ~op;
            tick();
            n++;
        end
        start = 1'b0;
        if (done === 1'b1) pulses++;
        checks++;
        if (result !== 8'h33) begin
            errors++;
            $display("FAIL stab_result: got %h want 33", result);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            checks++;
            if (result !== 8'h33) begin
                errors++;
                $display("FAIL stab_hold: cycle %0d got %h want 33", i, result);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL stab_done_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        op = 1'b0; a = 8'h0F; b = 8'h01; start = 1'b1;
        tick();              // T0
        start = 1'b0;
        tick();              // T1
        tick();              // T2
        rst_n = 1'b0;
        tick();              // T3 resets
        rst_n = 1'b1;
        checks++;
        if ({busy, done, result, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy, done, result, cout, ovf);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d active cycles want 0", pulses);
        end
        run_op("rstmid_add_01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea [3] = '{8'h01, 8'h50, 8'hC8};
        logic [7:0] eb [3] = '{8'h02, 8'h10, 8'h64};
        logic       eop[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] er [3] = '{8'h03, 8'h40, 8'h2C};
        logic       ec [3] = '{1'b0, 1'b1, 1'b1};
        int acc[3];
        int dn[3];
        int na;
        int nd;
        logic prev_busy;
        na = 0; nd = 0;
        prev_busy = busy;
        op = eop[0]; a = ea[0]; b = eb[0]; start = 1'b1;
        for (int cyc = 0; cyc < 60 && nd < 3; cyc++) begin
            tick();
            if (busy === 1'b1 && prev_busy !== 1'b1 && na < 3) begin
                acc[na] = cyc;
                na++;
            end
            prev_busy = busy;
            if (done === 1'b1) begin
                dn[nd] = cyc;
                checks++;
                if (result !== er[nd] || cout !== ec[nd]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got result=%h cout=%b want %h %b",
                             nd, result, cout, er[nd], ec[nd]);
                end
                nd++;
                if (nd < 3) begin
                    op = eop[nd]; a = ea[nd]; b = eb[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (na !== 3 || nd !== 3) begin
            errors++;
            $display("FAIL b2b_count: got accepts=%0d dones=%0d want 3 3", na, nd);
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (acc[k] - acc[k-1] !== 10) begin
                    errors++;
                    $display("FAIL b2b_accept_gap%0d: got %0d want 10", k, acc[k] - acc[k-1]);
                end
                checks++;
                if (dn[k] - dn[k-1] !== 10) begin
                    errors++;
                    $display("FAIL b2b_done_gap%0d: got %0d want 10", k, dn[k] - dn[k-1]);
                end
            end
            checks++;
            if (dn[0] - acc[0] !== 8) begin
                errors++;
                $display("FAIL b2b_latency: got %0d want 8", dn[0] - acc[0]);
            end
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_stability();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract controller for the two-function calculator. It sequences a single one-bit full adder cell over WIDTH clock cycles, LSB first, to produce a WIDTH-bit sum or difference. The full adder cell is instantiated internally. The block sits between the operand/function-select front end and the result display/register stage, and reports completion with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  request new operation; sampled only in IDLE
- op  in  1  0 = add (a+b), 1 = subtract (a−b)
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result/cout/ovf valid and stable
- result  out  WIDTH  registered result, held until next completion
- cout  out  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: on clk edge with start=1:
  - capture a into shift register SA;
  - capture (op ? ~b : b) into SB;
  - carry register ← op; bit counter ← 0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - full adder inputs are ai=SA[0], bi=SB[0], cini=carry;
  - si is shifted into the MSB of the internal sum register SR, whose contents shift right;
  - SA and SB shift right; carry ← couti; counter increments.
- RUN on the WIDTH-th bit (counter = WIDTH−1):
  - result ← final SR value;
  - cout ← couti;
  - ovf ← cini XOR couti of that MSB bit;
  - go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy=1. Operand or op changes after capture have no effect on the operation in flight.
- result, cout and ovf change only on the RUN→DONE edge. Partial sums are never visible on result.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- Reset (rst_n=0 at any clk edge, including mid-RUN or in DONE):
  - state → IDLE; busy, done, result, cout, ovf → 0;
  - the in-flight operation is discarded, with no done pulse;
  - internal registers are cleared.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0.
- Edge T0 samples start=1 in IDLE. busy=1 from after T0.
- Bits 0…WIDTH−1 are processed at edges T1…T_WIDTH.
- After edge T_WIDTH: done=1 and result valid, giving a latency of WIDTH clocks from the accepting edge.
- After edge T_(WIDTH+1): IDLE, busy=0, done=0.
- Earliest next accept is at edge T_(WIDTH+2). Throughput is one operation per WIDTH+2 clocks when start is held high.
- start high during the DONE cycle is not accepted. It is accepted on the following edge if still high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8:
  - Stimulus: add, a=0x25, b=0x1A.
  - Required: done exactly 8 clocks after the accepting edge; result=0x3F, cout=0, ovf=0; busy low 2 clocks after done rises.
- Signed add overflow and carry:
  - 0x7F+0x01 → result=0x80, ovf=1, cout=0.
  - 0xFF+0x01 → result=0x00, cout=1, ovf=0.
- Subtract:
  - 0x10−0x20 → result=0xF0, cout=0, ovf=0.
  - 0x80−0x01 → result=0x7F, ovf=1, cout=1.
  - 0x05−0x05 → result=0x00, cout=1.
- Stability while busy:
  - Stimulus: accept a=0x11, b=0x22 (add); then toggle start, a, b and op every cycle during RUN.
  - Required: result=0x33; exactly one done pulse; result held at 0x33 until the next completion.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge at T3 of an add.
  - Required: all outputs 0 the next cycle; no done pulse. A new start then completes correctly (0x01+0x01 → 0x02).
- Back-to-back:
  - Stimulus: start held high for three operations.
  - Required: accepting edges spaced exactly 10 clocks apart; done pulses spaced 10 clocks apart; each result correct.
